// File: rtl/apb_cmd_queue.sv
// apb_cmd_queue: command FIFO and one-at-a-time issue sequencer in front of the APB master.
// Define APB_CMDQ_WDOG_EN to add a WAIT-state watchdog of TIMEOUT apb_clk cycles.
module apb_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   apb_clk,
  input  logic                   sys_reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [7:0]             cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic                   m_data_valid,
  output logic [7:0]             m_addr,
  output logic [31:0]            m_data,
  output logic                   m_data_dir,
  input  logic [31:0]            m_read_out_data,
  input  logic                   m_transaction_done,
  input  logic                   m_tranerr
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_d;
  logic [40:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [40:0] head;
  logic push, pop, timeout;
  logic mdv_d, dir_d, rv_d, rw_d, re_d;
  logic [7:0] addr_d;
  logic [31:0] data_d, rd_d;
  assign head = mem[rd_ptr];
  // ready is withheld while reset is asserted, and never bypasses a full FIFO
  assign cmd_ready = sys_reset && (cmd_level != LW'(DEPTH));
  assign push = cmd_valid && cmd_ready;
`ifdef APB_CMDQ_WDOG_EN
  logic [31:0] wdog;
  assign timeout = (state == S_WAIT) && (wdog == 32'(TIMEOUT - 1));
  always_ff @(posedge apb_clk or negedge sys_reset)
    if (!sys_reset) wdog <= '0;
    else wdog <= (state == S_WAIT && state_d == S_WAIT) ? wdog + 32'd1 : '0;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge apb_clk)
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  always_comb begin
    state_d = state;
    pop = 1'b0;
    mdv_d = 1'b0;
    addr_d = m_addr;
    data_d = m_data;
    dir_d = m_data_dir;
    rv_d = rsp_valid;
    rw_d = rsp_write;
    rd_d = rsp_rdata;
    re_d = rsp_err;
    case (state)
      S_IDLE: if (cmd_level != '0) begin
        pop = 1'b1;
        mdv_d = 1'b1;
        addr_d = head[39:32];
        data_d = head[40] ? head[31:0] : '0;
        dir_d = head[40];
        state_d = S_WAIT;
      end
      S_WAIT: if (m_tranerr || timeout || m_transaction_done) begin
        rv_d = 1'b1;
        rw_d = m_data_dir;
        re_d = m_tranerr || timeout;
        rd_d = (m_tranerr || timeout || m_data_dir) ? '0 : m_read_out_data;
        state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) begin
        rv_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge apb_clk or negedge sys_reset)
    if (!sys_reset) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cmd_level <= '0;
      m_data_valid <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_data_dir <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_d;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cmd_level <= cmd_level + LW'(push) - LW'(pop);
      m_data_valid <= mdv_d;
      m_addr <= addr_d;
      m_data <= data_d;
      m_data_dir <= dir_d;
      rsp_valid <= rv_d;
      rsp_write <= rw_d;
      rsp_rdata <= rd_d;
      rsp_err <= re_d;
    end
endmodule

// File: tb/tb_apb_cmd_queue.sv
// tb_apb_cmd_queue: directed bench for apb_cmd_queue with a small behavioural APB master/slave.
module tb_apb_cmd_queue;
  logic apb_clk = 0, sys_reset = 0;
  logic cmd_valid = 0, cmd_write = 0, rsp_ready = 1;
  logic [7:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_write, rsp_err, m_data_valid, m_data_dir;
  logic [31:0] rsp_rdata, m_data, m_read_out_data;
  logic [7:0] m_addr;
  logic [2:0] cmd_level;
  logic done_m = 0, done_k = 0, terr = 0;
  logic [31:0] rdata_m = 0, rdata_k = 0;
  logic m_transaction_done, m_tranerr;
  int checks = 0, errors = 0, issues = 0, cyc = 0, issue_cyc = 0;
  int lat = 0, err_n = 0;
  logic hang = 0, prev_mdv = 0;
  logic [31:0] smem [256];
  logic [33:0] rq [$];

  assign m_transaction_done = done_m | done_k;
  assign m_tranerr = terr;
  assign m_read_out_data = done_k ? rdata_k : rdata_m;

  apb_cmd_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .apb_clk(apb_clk), .sys_reset(sys_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cmd_level(cmd_level),
    .m_data_valid(m_data_valid), .m_addr(m_addr), .m_data(m_data),
    .m_data_dir(m_data_dir), .m_read_out_data(m_read_out_data),
    .m_transaction_done(m_transaction_done), .m_tranerr(m_tranerr)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    logic acc = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge apb_clk); acc = cmd_ready;
      @(posedge apb_clk); #1;
    end
    cmd_valid = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 500 && rq.size() < n; i++) begin
      @(posedge apb_clk); #1;
    end
    chk("rsp_count", rq.size(), n);
  endtask

  task automatic wait_rv(output int at);
    at = -1;
    for (int i = 0; i < 100 && at < 0; i++) begin
      @(posedge apb_clk); #1;
      if (rsp_valid) at = cyc;
    end
    if (at < 0) chk("rsp_valid_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge apb_clk);
    cyc++;
  end

  // issue monitor: pulses must be single-cycle
  initial forever begin
    @(posedge apb_clk); #1;
    if (m_data_valid) begin
      issues++;
      issue_cyc = cyc;
      chk("mdv_single", prev_mdv, 0);
    end
    prev_mdv = m_data_valid;
  end

  initial forever begin
    @(negedge apb_clk);
    if (sys_reset && rsp_valid && rsp_ready) rq.push_back({rsp_write, rsp_err, rsp_rdata});
  end

  // behavioural master + zero-wait slave
  initial begin
    logic [7:0] ma;
    logic [31:0] md;
    logic mw;
    forever begin
      @(posedge apb_clk); #1;
      if (m_data_valid && !hang) begin
        ma = m_addr; md = m_data; mw = m_data_dir;
        repeat (lat) @(posedge apb_clk);
        if (lat > 0) #1;
        done_m = 1;
        if (err_n > 0) begin
          terr = 1;
          err_n--;
          rdata_m = 32'hDEAD;
        end else begin
          rdata_m = mw ? 32'hFFFF_FFFF : smem[ma];
          if (mw) smem[ma] = md;
        end
        @(posedge apb_clk); #1;
        done_m = 0; terr = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int rc, iss0;
    for (int i = 0; i < 256; i++) smem[i] = 0;
    smem[5] = 32'h55;
    repeat (3) @(posedge apb_clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_level", cmd_level, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mdv", m_data_valid, 0);
    chk("rst_maddr", {m_addr, m_data, m_data_dir}, 0);
    sys_reset = 1;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    push_cmd(1, 8'd4, 32'h0A);
    chk("t1_mdv_n", m_data_valid, 0);
    chk("t1_level1", cmd_level, 1);
    @(posedge apb_clk); #1;
    chk("t1_mdv_n1", m_data_valid, 1);
    chk("t1_level0", cmd_level, 0);
    chk("t1_master", {m_addr, m_data, m_data_dir}, {8'd4, 32'h0A, 1'b1});
    @(posedge apb_clk); #1;
    chk("t1_mdv_drop", m_data_valid, 0);
    chk("t1_addr_hold", {m_addr, m_data}, {8'd4, 32'h0A});
    push_cmd(0, 8'd4, 32'h77);
    wait_rsp(2);
    chk("t1_rsp0", rq[0], {1'b1, 1'b0, 32'h0});
    chk("t1_rsp1", rq[1], {1'b0, 1'b0, 32'h0A});
    chk("t1_issues", issues, 2);
    rq.delete();

    lat = 8;
    push_cmd(1, 8'd20, 32'h11);
    push_cmd(1, 8'd21, 32'h22);
    push_cmd(0, 8'd20, 32'h0);
    push_cmd(0, 8'd21, 32'h0);
    push_cmd(0, 8'd4, 32'h0);
    chk("t2_full_level", cmd_level, 4);
    chk("t2_full_ready", cmd_ready, 0);
    push_cmd(1, 8'd20, 32'h33);
    wait_rsp(6);
    chk("t2_r0", rq[0], {1'b1, 1'b0, 32'h0});
    chk("t2_r1", rq[1], {1'b1, 1'b0, 32'h0});
    chk("t2_r2", rq[2], {1'b0, 1'b0, 32'h11});
    chk("t2_r3", rq[3], {1'b0, 1'b0, 32'h22});
    chk("t2_r4", rq[4], {1'b0, 1'b0, 32'h0A});
    chk("t2_r5", rq[5], {1'b1, 1'b0, 32'h0});
    rq.delete();

    lat = 0;
    rsp_ready = 0;
    push_cmd(0, 8'd5, 32'h0);
    push_cmd(0, 8'd4, 32'h0);
    wait_rv(rc);
    iss0 = issues;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h55});
      @(posedge apb_clk); #1;
    end
    chk("t3_no_issue", issues, iss0);
    rsp_ready = 1;
    wait_rsp(2);
    chk("t3_r0", rq[0], {1'b0, 1'b0, 32'h55});
    chk("t3_r1", rq[1], {1'b0, 1'b0, 32'h0A});
    rq.delete();

    lat = 2;
    err_n = 1;
    push_cmd(0, 8'd4, 32'h0);
    push_cmd(0, 8'd5, 32'h0);
    wait_rsp(2);
    chk("t4_err", rq[0], {1'b0, 1'b1, 32'h0});
    chk("t4_next", rq[1], {1'b0, 1'b0, 32'h55});
    rq.delete();

    lat = 0;
    hang = 1;
    push_cmd(0, 8'd4, 32'h0);
    push_cmd(0, 8'd5, 32'h0);
    push_cmd(1, 8'd6, 32'h9);
    push_cmd(0, 8'd4, 32'h0);
    chk("t5_level3", cmd_level, 3);
    sys_reset = 0;
    #1;
    chk("t5_rst", {cmd_level, rsp_valid, m_data_valid, cmd_ready}, 0);
    chk("t5_rst_master", {m_addr, m_data, m_data_dir}, 0);
    @(posedge apb_clk); @(posedge apb_clk); #1;
    sys_reset = 1;
    hang = 0;
    iss0 = issues;
    repeat (10) @(posedge apb_clk);
    #1;
    chk("t5_no_stale", issues, iss0);
    chk("t5_no_rsp", rq.size(), 0);
    chk("t5_ready", {cmd_ready, cmd_level}, {1'b1, 3'd0});

    hang = 1;
`ifdef APB_CMDQ_WDOG_EN
    rsp_ready = 0;
    push_cmd(0, 8'd4, 32'h0);
    wait_rv(rc);
    chk("t6_wdog_lat", rc - issue_cyc, 8);
    chk("t6_wdog_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0});
    rdata_k = 32'h1234; done_k = 1;
    @(posedge apb_clk); #1;
    done_k = 0;
    chk("t6_late_done", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    rsp_ready = 1;
    wait_rsp(1);
    chk("t6_r0", rq[0], {1'b0, 1'b1, 32'h0});
    done_k = 1;
    @(posedge apb_clk); #1;
    done_k = 0;
    repeat (3) @(posedge apb_clk);
    #1;
    chk("t6_idle_done", rsp_valid, 0);
`else
    push_cmd(0, 8'd4, 32'h0);
    repeat (30) @(posedge apb_clk);
    #1;
    chk("t6_no_wdog", rsp_valid, 0);
    rdata_k = 32'h1234; done_k = 1;
    @(posedge apb_clk); #1;
    done_k = 0;
    wait_rsp(1);
    chk("t6_done", rq[0], {1'b0, 1'b0, 32'h1234});
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
